// File: rtl/exp_pkg.sv
// Shared constants for the exp accelerator and its result buffer.
package exp_pkg;

  localparam int unsigned RESULT_W  = 21;
  localparam int unsigned VI_W      = 5;
  localparam int unsigned UI_W      = 2;
  localparam int unsigned BUF_DEPTH = 8;

  typedef struct packed {
    logic                last;
    logic [RESULT_W-1:0] data;
  } result_entry_t;

endpackage

// File: rtl/exp_result_buffer_if.sv
// Producer/consumer bundle of the result buffer; master drives requests, slave is the buffer.
interface exp_result_buffer_if #(
  parameter int unsigned DATA_W = exp_pkg::RESULT_W,
  parameter int unsigned DEPTH  = exp_pkg::BUF_DEPTH
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              rd_en;
  logic              clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [7:0]        frame_cnt;

  modport master (
    output wr_req, wr_data, done, rd_en, clr,
    input  rd_data, rd_last, rd_valid, empty, full, count, overflow, frame_cnt
  );

  modport slave (
    input  wr_req, wr_data, done, rd_en, clr,
    output rd_data, rd_last, rd_valid, empty, full, count, overflow, frame_cnt
  );

endinterface

// File: rtl/exp_result_mem.sv
// Result storage: DEPTH words of {last tag, data}, synchronous write, registered read.
module exp_result_mem #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DATA_W:0] wr_word_i,
  input  logic          tag_set_i,
  input  logic [AW-1:0] tag_addr_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DATA_W:0] rd_word_o
);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [DATA_W:0] rd_word_q, rd_word_d;

  // Array is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_word_i;
    end
    if (tag_set_i) begin
      mem_q[tag_addr_i][DATA_W] <= 1'b1;
    end
  end

  always_comb begin
    rd_word_d = rd_word_q;
    if (rd_en_i) begin
      rd_word_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_word_q <= '0;
    end else begin
      rd_word_q <= rd_word_d;
    end
  end

  assign rd_word_o = rd_word_q;

endmodule

// File: rtl/exp_result_buffer.sv
// Result FIFO between the exp accelerator and its consumer, with frame tagging and overflow.
module exp_result_buffer
  import exp_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_W,
  parameter int unsigned DEPTH  = BUF_DEPTH
) (
  input logic                clk,
  input logic                rst,
  exp_result_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             empty, full;
  logic             rd_accept, wr_accept, tag_set;
  logic [DATA_W:0]  rd_word;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign rd_accept = bus.rd_en & ~empty & ~bus.clr;
  assign wr_accept = bus.wr_req & (~full | rd_accept) & ~bus.clr;
  // A late done marks the newest entry, unless that entry is leaving this cycle.
  assign tag_set   = bus.done & ~bus.wr_req & ~bus.clr & (count_q > CNT_W'(rd_accept));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q;
    rd_valid_d  = rd_accept;
    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      frame_cnt_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CNT_W'(1);
      end
      if (bus.wr_req && !wr_accept) begin
        overflow_d = 1'b1;
      end
      if (bus.done) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  exp_result_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i      (clk),
    .rst_ni     (rst),
    .wr_en_i    (wr_accept),
    .wr_addr_i  (wr_ptr_q),
    .wr_word_i  ({bus.done, bus.wr_data}),
    .tag_set_i  (tag_set),
    .tag_addr_i (wr_ptr_q - PTR_W'(1)),
    .rd_en_i    (rd_accept),
    .rd_addr_i  (rd_ptr_q),
    .rd_word_o  (rd_word)
  );

  assign bus.rd_data   = rd_word[DATA_W-1:0];
  assign bus.rd_last   = rd_word[DATA_W];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_exp_result_buffer.sv
// Directed bench for exp_result_buffer: queue-based reference model plus literal expectations.
module tb_exp_result_buffer;
  import exp_pkg::*;

  localparam int unsigned DATA_W = RESULT_W;
  localparam int unsigned DEPTH  = BUF_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  exp_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  result_entry_t mq[$];
  result_entry_t got[$];
  logic          m_ovf;
  logic [7:0]    m_fc;
  logic          m_vld;
  result_entry_t m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs presented to it.
  task automatic model_step();
    bit rd_ok, wr_ok;
    result_entry_t e;
    rd_ok = bus.rd_en && (mq.size() != 0) && !bus.clr;
    wr_ok = bus.wr_req && ((mq.size() < DEPTH) || rd_ok) && !bus.clr;
    m_vld = rd_ok;
    if (bus.clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_fc  = 8'd0;
    end else begin
      if (rd_ok) m_out = mq.pop_front();
      if (wr_ok) begin
        e.last = bus.done;
        e.data = bus.wr_data;
        mq.push_back(e);
      end else if (bus.wr_req) begin
        m_ovf = 1'b1;
      end
      if (bus.done && !bus.wr_req && (mq.size() != 0)) begin
        e = mq[mq.size()-1];
        e.last = 1'b1;
        mq[mq.size()-1] = e;
      end
      if (bus.done) m_fc = m_fc + 8'd1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        m_ovf = 1'b0;
        m_fc  = 8'd0;
        m_vld = 1'b0;
        m_out = '0;
      end
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fc));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_vld));
      if (m_vld) begin
        chk("rd_data", 32'(bus.rd_data), 32'(m_out.data));
        chk("rd_last", 32'(bus.rd_last), 32'(m_out.last));
      end
      if (bus.rd_valid === 1'b1) got.push_back({bus.rd_last, bus.rd_data});
      if (rst) model_step();
    end
  end

  task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic dn,
                     input logic r, input logic c);
    bus.wr_req  = w;
    bus.wr_data = d;
    bus.done    = dn;
    bus.rd_en   = r;
    bus.clr     = c;
    @(posedge clk);
    #1;
    bus.wr_req  = 1'b0;
    bus.wr_data = '0;
    bus.done    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr     = 1'b0;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input logic dn);
    cyc(1'b1, d, dn, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic flush();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [DATA_W-1:0] d, input logic last);
    result_entry_t e;
    if (got.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no word expected %0h", name, d);
    end else begin
      e = got.pop_front();
      chk({name, "_data"}, 32'(e.data), 32'(d));
      chk({name, "_last"}, 32'(e.last), 32'(last));
    end
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_data = '0;
    bus.done    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr     = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic frame: three words, done on the last.
    wr(21'h00ABC, 1'b0);
    wr(21'h1FFFF, 1'b0);
    wr(21'h00001, 1'b1);
    rd(); rd(); rd();
    idle(2);
    pop_chk("t1_w0", 21'h00ABC, 1'b0);
    pop_chk("t1_w1", 21'h1FFFF, 1'b0);
    pop_chk("t1_w2", 21'h00001, 1'b1);
    chk("t1_frames", 32'(bus.frame_cnt), 32'd1);

    // Fill, overflow, drain.
    flush();
    for (int i = 0; i < 8; i++) wr(21'h10000 + 21'(i), 1'b0);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd8);
    wr(21'h12345, 1'b0);
    chk("t2_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) rd();
    idle(2);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t2_w%0d", i), 21'h10000 + 21'(i), 1'b0);
    chk("t2_extra", 32'(got.size()), 32'd0);

    // Simultaneous write and read on a full buffer.
    flush();
    for (int i = 0; i < 8; i++) wr(21'h20000 + 21'(i), 1'b0);
    cyc(1'b1, 21'h0ABCD, 1'b0, 1'b1, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd8);
    chk("t3_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) rd();
    idle(2);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t3_w%0d", i), 21'h20000 + 21'(i), 1'b0);
    pop_chk("t3_new", 21'h0ABCD, 1'b0);

    // Reads on empty, no fall-through.
    flush();
    rd();
    idle(2);
    chk("t4_empty_rd", 32'(got.size()), 32'd0);
    cyc(1'b1, 21'h00555, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t4_no_ft", 32'(got.size()), 32'd0);
    rd();
    idle(2);
    pop_chk("t4_w", 21'h00555, 1'b0);

    // done arriving after the last word tags it.
    flush();
    wr(21'h00011, 1'b0);
    wr(21'h00022, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    rd(); rd();
    idle(2);
    pop_chk("t5_w0", 21'h00011, 1'b0);
    pop_chk("t5_w1", 21'h00022, 1'b1);

    // clr with a concurrent write.
    flush();
    for (int i = 0; i < 5; i++) wr(21'h30000 + 21'(i), (i == 2));
    chk("t6_frames", 32'(bus.frame_cnt), 32'd1);
    cyc(1'b1, 21'h3FFFF, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_frames0", 32'(bus.frame_cnt), 32'd0);
    rd();
    idle(2);
    chk("t6_no_rd", 32'(got.size()), 32'd0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 8; i++) wr(21'h40000 + 21'(i), 1'b0);
    wr(21'h1ABCD, 1'b0);
    for (int i = 0; i < 4; i++) rd();
    idle(2);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("t7_w%0d", i), 21'h40000 + 21'(i), 1'b0);
    chk("t7_count", 32'(bus.count), 32'd4);
    chk("t7_ovf", 32'(bus.overflow), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t7_r_valid", 32'(bus.rd_valid), 32'd0);
    chk("t7_r_data", 32'(bus.rd_data), 32'd0);
    chk("t7_r_last", 32'(bus.rd_last), 32'd0);
    chk("t7_r_empty", 32'(bus.empty), 32'd1);
    chk("t7_r_full", 32'(bus.full), 32'd0);
    chk("t7_r_count", 32'(bus.count), 32'd0);
    chk("t7_r_ovf", 32'(bus.overflow), 32'd0);
    chk("t7_r_frames", 32'(bus.frame_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    wr(21'h0000F, 1'b0);
    rd();
    idle(2);
    pop_chk("t7_after", 21'h0000F, 1'b0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
